// File: rtl/writeback_queue.sv
// writeback_queue: in-order buffer between the execute/memory stages and the
// register file write port. Loads and ALU results arrive over valid/ready,
// drain one per cycle to the register file, and can be forwarded while pending.
//
// Handshake: a producer holds valid (and its payload) until it sees ready in
// the same cycle; the transfer happens on the posedge where valid && ready.
// ready never depends on the producer's own valid; alu_ready only depends on
// mem_valid because a load takes the single push slot.
module writeback_queue #(
    parameter int WORD_SIZE = 32,
    parameter int ADDRES    = $clog2(WORD_SIZE),
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDRES-1:0]    alu_addres,
    input  logic [WORD_SIZE-1:0] alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDRES-1:0]    mem_addres,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 stall,
    output logic                 signal_we,
    output logic [ADDRES-1:0]    addres_write,
    output logic [WORD_SIZE-1:0] data_write,
    input  logic [ADDRES-1:0]    lookup_addres_1,
    output logic                 lookup_hit_1,
    output logic [WORD_SIZE-1:0] lookup_data_1,
    input  logic [ADDRES-1:0]    lookup_addres_2,
    output logic                 lookup_hit_2,
    output logic [WORD_SIZE-1:0] lookup_data_2,
    output logic                 full,
    output logic                 empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDRES-1:0]    addr_mem_q [DEPTH];
    logic [WORD_SIZE-1:0] data_mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 full_q, empty_q;
    logic                 we_q;
    logic [ADDRES-1:0]    aw_q;
    logic [WORD_SIZE-1:0] dw_q;

    logic                 mem_fire, alu_fire, enq, pop;
    logic [ADDRES-1:0]    push_addr;
    logic [WORD_SIZE-1:0] push_data;
    logic [WORD_SIZE:0]   look_1, look_2;

    // Arbitration: load wins the single push slot; nothing accepted when full or in reset.
    always_comb begin
        mem_ready = !rst && !full_q;
        alu_ready = !rst && !full_q && !mem_valid;
        mem_fire  = mem_valid && mem_ready;
        alu_fire  = alu_valid && alu_ready;
        push_addr = mem_fire ? mem_addres : alu_addres;
        push_data = mem_fire ? mem_data : alu_data;
        // Writes to $zero complete the handshake but are dropped here.
        enq       = (mem_fire || alu_fire) && (push_addr != '0);
        pop       = !stall && !empty_q;
        wr_ptr_d  = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(enq) - CW'(pop);
    end

    // Pointers, occupancy and the registered full/empty flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    // Entry storage; contents are only meaningful inside the occupied window.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            addr_mem_q[wr_ptr_q] <= push_addr;
            data_mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Registered write port: present the head for one cycle per pop, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q <= 1'b0;
            aw_q <= '0;
            dw_q <= '0;
        end else if (pop) begin
            we_q <= 1'b1;
            aw_q <= addr_mem_q[rd_ptr_q];
            dw_q <= data_mem_q[rd_ptr_q];
        end else begin
            we_q <= 1'b0;
        end
    end

    // Youngest pending value for a register: output stage is oldest, then the
    // FIFO from head to tail so later matches override earlier ones.
    function automatic logic [WORD_SIZE:0] lookup(input logic [ADDRES-1:0] a);
        logic [WORD_SIZE:0] r;
        logic [PW-1:0]      idx;
        r   = '0;
        idx = '0;
        if (a != '0) begin
            if (we_q && aw_q == a) r = {1'b1, dw_q};
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PW'(i);
                if (CW'(i) < count_q && addr_mem_q[idx] == a) r = {1'b1, data_mem_q[idx]};
            end
        end
        return r;
    endfunction

    // Two independent forwarding ports share the same search.
    always_comb begin
        look_1 = lookup(lookup_addres_1);
        look_2 = lookup(lookup_addres_2);
    end

    assign lookup_hit_1  = look_1[WORD_SIZE];
    assign lookup_data_1 = look_1[WORD_SIZE-1:0];
    assign lookup_hit_2  = look_2[WORD_SIZE];
    assign lookup_data_2 = look_2[WORD_SIZE-1:0];
    assign signal_we     = we_q;
    assign addres_write  = aw_q;
    assign data_write    = dw_q;
    assign full          = full_q;
    assign empty         = empty_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: drivers offer results and queue the
// expected commits; a monitor checks every register-file write against them.
module tb_writeback_queue;

  localparam int W  = 32;
  localparam int A  = 5;
  localparam int EW = A + W;

  logic         clk = 1'b0;
  logic         rst;
  logic         alu_valid, mem_valid, stall;
  logic         alu_ready, mem_ready;
  logic [A-1:0] alu_addres, mem_addres;
  logic [W-1:0] alu_data, mem_data;
  logic         signal_we;
  logic [A-1:0] addres_write;
  logic [W-1:0] data_write;
  logic [A-1:0] lookup_addres_1, lookup_addres_2;
  logic         lookup_hit_1, lookup_hit_2;
  logic [W-1:0] lookup_data_1, lookup_data_2;
  logic         full, empty;

  int tests_run = 0;
  int tests_failed = 0;
  logic [EW-1:0] exp_q[$];

  writeback_queue #(.WORD_SIZE(W), .ADDRES(A), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addres(alu_addres), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addres(mem_addres), .mem_data(mem_data),
    .stall(stall),
    .signal_we(signal_we), .addres_write(addres_write), .data_write(data_write),
    .lookup_addres_1(lookup_addres_1), .lookup_hit_1(lookup_hit_1), .lookup_data_1(lookup_data_1),
    .lookup_addres_2(lookup_addres_2), .lookup_hit_2(lookup_hit_2), .lookup_data_2(lookup_data_2),
    .full(full), .empty(empty)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every write must match the oldest expected commit
  always @(negedge clk) begin
    if (signal_we === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_write: got reg %0d data %0h expected no write", addres_write, data_write);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({addres_write, data_write} !== e) begin
          tests_failed++;
          $display("FAIL commit: got reg %0d data %0h expected reg %0d data %0h",
                   addres_write, data_write, e[EW-1:W], e[W-1:0]);
        end
      end
    end
  end

  // driver tasks: called just after a negedge, return just after the next negedge
  task automatic offer_alu(input logic [A-1:0] a, input logic [W-1:0] d, input logic exp_rdy,
                           input logic [EW-1:0] exp_commit, input logic commit);
    alu_valid = 1'b1; alu_addres = a; alu_data = d;
    #1 check("alu_ready", alu_ready, exp_rdy);
    if (commit) exp_q.push_back(exp_commit);
    @(posedge clk); @(negedge clk);
    alu_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (empty === 1'b1 && signal_we === 1'b0) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) check("drain_timeout", 1, 0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    alu_valid = 1'b1; alu_addres = 5'd9; alu_data = 32'h99999999;
    mem_valid = 1'b0; mem_addres = '0; mem_data = '0;
    lookup_addres_1 = '0; lookup_addres_2 = '0;

    // reset held two cycles with an offer pending
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_we", signal_we, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_addres_write", addres_write, 0);
    alu_valid = 1'b0; rst = 1'b0;
    #1 check("post_rst_alu_ready", alu_ready, 1);
    check("post_rst_mem_ready", mem_ready, 1);

    // single ALU write: committed after the second edge, for one cycle
    offer_alu(5'd5, 32'hA5B5C5D5, 1, {5'd5, 32'hA5B5C5D5}, 1);
    #1 check("lat_we_edge1", signal_we, 0);
    check("lat_fwd_pending", {lookup_hit_1, lookup_data_1}, {1'b0, 32'h0});
    lookup_addres_1 = 5'd5;
    #1 check("lat_fwd_queue", {lookup_hit_1, lookup_data_1}, {1'b1, 32'hA5B5C5D5});
    step();
    #1 check("lat_we_edge2", signal_we, 1);
    check("lat_addr", addres_write, 5);
    check("lat_data", data_write, 32'hA5B5C5D5);
    check("lat_empty", empty, 1);
    step();
    #1 check("lat_we_drop", signal_we, 0);
    check("lat_hold_addr", addres_write, 5);

    // priority: load wins, ALU follows next cycle, commits in that order
    mem_valid = 1'b1; mem_addres = 5'd1; mem_data = 32'hA1B1C1D1;
    alu_valid = 1'b1; alu_addres = 5'd2; alu_data = 32'hA2B2C2D2;
    #1 check("prio_mem_ready", mem_ready, 1);
    check("prio_alu_blocked", alu_ready, 0);
    exp_q.push_back({5'd1, 32'hA1B1C1D1});
    step();
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    offer_alu(5'd2, 32'hA2B2C2D2, 1, {5'd2, 32'hA2B2C2D2}, 1);
    #1 check("prio_first_commit", {signal_we, addres_write}, {1'b1, 5'd1});
    step();
    #1 check("prio_second_commit", {signal_we, addres_write}, {1'b1, 5'd2});
    wait_idle();

    // full under stall, then in-order drain
    stall = 1'b1;
    offer_alu(5'd3, 32'h33333333, 1, {5'd3, 32'h33333333}, 1);
    offer_alu(5'd4, 32'h44444444, 1, {5'd4, 32'h44444444}, 1);
    offer_alu(5'd6, 32'h66666666, 1, {5'd6, 32'h66666666}, 1);
    offer_alu(5'd7, 32'h77777777, 1, {5'd7, 32'h77777777}, 1);
    #1 check("full_flag", full, 1);
    check("full_mem_ready", mem_ready, 0);
    offer_alu(5'd9, 32'h99999999, 0, '0, 0);
    #1 check("stall_no_we", signal_we, 0);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      #1 check("drain_back_to_back", signal_we, 1);
    end
    wait_idle();
    check("drain_empty", empty, 1);

    // forwarding: youngest value wins, miss returns zero, $zero dropped
    stall = 1'b1;
    offer_alu(5'd6, 32'h11111111, 1, {5'd6, 32'h11111111}, 1);
    offer_alu(5'd6, 32'h22222222, 1, {5'd6, 32'h22222222}, 1);
    lookup_addres_1 = 5'd6; lookup_addres_2 = 5'd8;
    #1 check("fwd_hit_youngest", {lookup_hit_1, lookup_data_1}, {1'b1, 32'h22222222});
    check("fwd_miss", {lookup_hit_2, lookup_data_2}, {1'b0, 32'h0});
    offer_alu(5'd0, 32'hDEADBEEF, 1, '0, 0);
    lookup_addres_1 = 5'd0;
    #1 check("fwd_zero_miss", {lookup_hit_1, lookup_data_1}, {1'b0, 32'h0});
    check("zero_not_enqueued", full, 0);
    lookup_addres_1 = 5'd6;
    stall = 1'b0;
    step();
    #1 check("fwd_queue_over_stage", {lookup_hit_1, lookup_data_1}, {1'b1, 32'h22222222});
    step();
    #1 check("fwd_output_stage", {signal_we, lookup_hit_1, lookup_data_1}, {1'b1, 1'b1, 32'h22222222});
    step();
    #1 check("fwd_after_commit", {lookup_hit_1, lookup_data_1}, {1'b0, 32'h0});
    wait_idle();

    // reset with entries queued: nothing may be written afterwards
    stall = 1'b1;
    offer_alu(5'd10, 32'h10101010, 1, {5'd10, 32'h10101010}, 1);
    offer_alu(5'd11, 32'h11011011, 1, {5'd11, 32'h11011011}, 1);
    offer_alu(5'd12, 32'h12121212, 1, {5'd12, 32'h12121212}, 1);
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0; stall = 1'b0;
    #1 check("midrst_empty", empty, 1);
    check("midrst_we", signal_we, 0);
    check("midrst_lookup", lookup_hit_1, 0);
    for (int i = 0; i < 8; i++) step();
    #1 check("midrst_still_empty", empty, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
